clock_set_ctrl: RTL and testbench

Time-setting controller for the digital clock. It consumes the debounced, auto-repeating 1-cycle button pulses (mode/up/down) and sequences the timekeeper through RUN and the per-field edit states. It holds a shadow copy of hh:mm:ss, edits it with wrap-around, and commits it with a single load strobe. It also drives field-select and blink for the display mux.

---
 rtl/clock_pkg.sv | 19 +
 rtl/mod_updown.sv | 24 ++
 rtl/clock_set_ctrl.sv | 160 ++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the clock time-setting controller: state encoding,
// per-field limits and field widths.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } state_t;

  localparam int HOUR_MAX = 23;
  localparam int MIN_MAX  = 59;
  localparam int SEC_MAX  = 59;

  localparam int H_W = 5;
  localparam int M_W = 6;

endpackage

// File: rtl/mod_updown.sv
// Wrap-around +/-1 step for one time field. up and down together leave the
// value unchanged.
module mod_updown #(
  parameter int MAX   = 59,
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] value,
  input  logic             up,
  input  logic             down,
  output logic [WIDTH-1:0] next
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  always_comb begin
    next = value;
    if (up && !down) begin
      next = (value >= MAX_V) ? '0 : value + 1'b1;
    end else if (down && !up) begin
      next = (value == '0 || value > MAX_V) ? MAX_V : value - 1'b1;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: RUN -> SET_H -> SET_M -> SET_S -> RUN with a shadow
// hh:mm:ss, edit timeout and field blink. Define SEC_ZERO_EN to drop SET_S and
// commit with seconds cleared.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_HZ    = 1000000,
  parameter int TIMEOUT_S = 10,
  parameter int BLINK_HZ  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mode_p,
  input  logic           up_p,
  input  logic           down_p,
  input  logic [H_W-1:0] cur_h,
  input  logic [M_W-1:0] cur_m,
  input  logic [M_W-1:0] cur_s,
  output logic           run_en,
  output logic           load,
  output logic [H_W-1:0] load_h,
  output logic [M_W-1:0] load_m,
  output logic [M_W-1:0] load_s,
  output logic [1:0]     sel,
  output logic           blink
);

  localparam int TIMEOUT_CYCLES = TIMEOUT_S * CLK_HZ;
  localparam int HALF_CYCLES    = CLK_HZ / (2 * BLINK_HZ);
  localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BL_W           = $clog2(HALF_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(HALF_CYCLES - 1);

  state_t          state_q, state_d;
  logic [H_W-1:0]  h_q, h_d, h_step;
  logic [M_W-1:0]  m_q, m_d, m_step;
  logic [M_W-1:0]  s_q, s_d, s_step;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [BL_W-1:0] bl_cnt_q, bl_cnt_d;
  logic            blink_q, blink_d;
  logic            load_q, load_d;
  logic            run_en_q, run_en_d;
  logic [1:0]      sel_q, sel_d;
  logic            edit_pulse;

  assign edit_pulse = up_p | down_p;

  mod_updown #(.MAX(HOUR_MAX), .WIDTH(H_W)) u_hours (
    .value(h_q), .up(up_p), .down(down_p), .next(h_step)
  );

  mod_updown #(.MAX(MIN_MAX), .WIDTH(M_W)) u_minutes (
    .value(m_q), .up(up_p), .down(down_p), .next(m_step)
  );

  mod_updown #(.MAX(SEC_MAX), .WIDTH(M_W)) u_seconds (
    .value(s_q), .up(up_p), .down(down_p), .next(s_step)
  );

  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    m_d      = m_q;
    s_d      = s_q;
    load_d   = 1'b0;
    to_cnt_d = '0;
    bl_cnt_d = '0;
    blink_d  = 1'b0;

    if (state_q == RUN) begin
      if (mode_p) begin
        state_d = SET_H;
        h_d     = cur_h;
        m_d     = cur_m;
        s_d     = cur_s;
      end
    end else if (mode_p) begin
      // Mode wins over a coincident up/down pulse.
      case (state_q)
        SET_H: state_d = SET_M;
`ifdef SEC_ZERO_EN
        SET_M: begin
          state_d = RUN;
          load_d  = 1'b1;
          s_d     = '0;
        end
`else
        SET_M: state_d = SET_S;
        SET_S: begin
          state_d = RUN;
          load_d  = 1'b1;
        end
`endif
        default: state_d = RUN;
      endcase
    end else if (edit_pulse) begin
      case (state_q)
        SET_H:   h_d = h_step;
        SET_M:   m_d = m_step;
        SET_S:   s_d = s_step;
        default: ;
      endcase
    end else if (to_cnt_q == TO_LAST) begin
      state_d = RUN;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    // Blink restarts visible on entry to a field and on every adjustment.
    if (state_d == RUN || state_d != state_q || edit_pulse) begin
      blink_d  = 1'b0;
      bl_cnt_d = '0;
    end else if (bl_cnt_q == BL_LAST) begin
      blink_d  = ~blink_q;
      bl_cnt_d = '0;
    end else begin
      blink_d  = blink_q;
      bl_cnt_d = bl_cnt_q + 1'b1;
    end

    run_en_d = (state_d == RUN);
    sel_d    = state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      h_q      <= '0;
      m_q      <= '0;
      s_q      <= '0;
      to_cnt_q <= '0;
      bl_cnt_q <= '0;
      blink_q  <= 1'b0;
      load_q   <= 1'b0;
      run_en_q <= 1'b1;
      sel_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      h_q      <= h_d;
      m_q      <= m_d;
      s_q      <= s_d;
      to_cnt_q <= to_cnt_d;
      bl_cnt_q <= bl_cnt_d;
      blink_q  <= blink_d;
      load_q   <= load_d;
      run_en_q <= run_en_d;
      sel_q    <= sel_d;
    end
  end

  assign run_en = run_en_q;
  assign load   = load_q;
  assign load_h = h_q;
  assign load_m = m_q;
  assign load_s = s_q;
  assign sel    = sel_q;
  assign blink  = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with a 1000 Hz clock, 1 s timeout and
// 2 Hz blink; the SEC_ZERO_EN build follows the shorter commit path.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode_p, up_p, down_p;
  logic [4:0] cur_h;
  logic [5:0] cur_m, cur_s;
  logic       run_en, load, blink;
  logic [4:0] load_h;
  logic [5:0] load_m, load_s;
  logic [1:0] sel;

  int vectors     = 0;
  int miscompares = 0;
  int load_count  = 0;
  int load_mark;

  clock_set_ctrl #(.CLK_HZ(1000), .TIMEOUT_S(1), .BLINK_HZ(2)) dut (
    .clk(clk), .rst_n(rst_n), .mode_p(mode_p), .up_p(up_p), .down_p(down_p),
    .cur_h(cur_h), .cur_m(cur_m), .cur_s(cur_s),
    .run_en(run_en), .load(load), .load_h(load_h), .load_m(load_m),
    .load_s(load_s), .sel(sel), .blink(blink)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (load) load_count++;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One-cycle pulse sampled by a single rising edge; returns on the next falling edge.
  task automatic applyStimulus(input logic m, input logic u, input logic d);
    @(negedge clk);
    mode_p = m; up_p = u; down_p = d;
    @(negedge clk);
    mode_p = 1'b0; up_p = 1'b0; down_p = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; mode_p = 1'b0; up_p = 1'b0; down_p = 1'b0;
    cur_h = 5'd12; cur_m = 6'd34; cur_s = 6'd56;
    idle(2);
    checkOutput("rst_run_en", run_en, 1);
    checkOutput("rst_load", load, 0);
    checkOutput("rst_sel", sel, 0);
    checkOutput("rst_blink", blink, 0);
    checkOutput("rst_load_h", load_h, 0);
    rst_n = 1'b1;
    idle(1);

    applyStimulus(1, 0, 0);
    checkOutput("enter_sel", sel, 1);
    checkOutput("enter_run_en", run_en, 0);
    checkOutput("enter_h", load_h, 12);
    checkOutput("enter_m", load_m, 34);
    checkOutput("enter_s", load_s, 56);
    checkOutput("enter_blink", blink, 0);

    repeat (11) applyStimulus(0, 1, 0);
    checkOutput("h_up_to_23", load_h, 23);
    applyStimulus(0, 1, 0);
    checkOutput("h_wrap_up", load_h, 0);
    applyStimulus(0, 0, 1);
    checkOutput("h_wrap_down", load_h, 23);
    repeat (8) applyStimulus(0, 1, 0);
    checkOutput("h_set_7", load_h, 7);
    checkOutput("h_edit_m_untouched", load_m, 34);

    applyStimulus(1, 0, 0);
    checkOutput("setm_sel", sel, 2);
    repeat (34) applyStimulus(0, 0, 1);
    checkOutput("m_down_to_0", load_m, 0);
    applyStimulus(0, 0, 1);
    checkOutput("m_wrap_down", load_m, 59);
    applyStimulus(0, 1, 0);
    checkOutput("m_wrap_up", load_m, 0);
    repeat (5) applyStimulus(0, 1, 0);
    checkOutput("m_set_5", load_m, 5);
    applyStimulus(0, 1, 1);
    checkOutput("m_up_down_same", load_m, 5);
    checkOutput("m_up_down_sel", sel, 2);

    applyStimulus(1, 1, 0);
`ifdef SEC_ZERO_EN
    checkOutput("commit_load", load, 1);
    checkOutput("commit_h", load_h, 7);
    checkOutput("commit_m", load_m, 5);
    checkOutput("commit_s_zero", load_s, 0);
    checkOutput("commit_run_en", run_en, 1);
    checkOutput("commit_sel", sel, 0);
`else
    checkOutput("mode_up_sel", sel, 3);
    checkOutput("mode_up_m_kept", load_m, 5);
    checkOutput("mode_up_load", load, 0);
    repeat (4) applyStimulus(0, 1, 0);
    checkOutput("s_wrap_up", load_s, 0);
    repeat (30) applyStimulus(0, 0, 1);
    checkOutput("s_set_30", load_s, 30);
    applyStimulus(1, 0, 0);
    checkOutput("commit_load", load, 1);
    checkOutput("commit_h", load_h, 7);
    checkOutput("commit_m", load_m, 5);
    checkOutput("commit_s", load_s, 30);
    checkOutput("commit_run_en", run_en, 1);
    checkOutput("commit_sel", sel, 0);
`endif
    idle(1);
    checkOutput("load_one_cycle", load, 0);

    // Idle timeout: all three buttons in RUN act as mode only.
    load_mark = load_count;
    applyStimulus(1, 1, 1);
    checkOutput("run_all_sel", sel, 1);
    checkOutput("run_all_h", load_h, 12);
    idle(999);
    checkOutput("to_before_expiry", sel, 1);
    idle(1);
    checkOutput("to_expired_sel", sel, 0);
    checkOutput("to_expired_run_en", run_en, 1);
    checkOutput("to_no_load", load_count, load_mark);

    // A pulse on the 999th cycle restarts the count.
    applyStimulus(1, 0, 0);
    idle(997);
    applyStimulus(0, 1, 0);
    checkOutput("restart_h", load_h, 13);
    idle(1);
    checkOutput("restart_held", sel, 1);
    idle(998);
    checkOutput("restart_before_expiry", sel, 1);
    idle(1);
    checkOutput("restart_expired", sel, 0);
    checkOutput("restart_no_load", load_count, load_mark);

    // Blink half-period is 250 cycles; an up pulse forces it visible.
    applyStimulus(1, 0, 0);
    checkOutput("blink_entry", blink, 0);
    idle(249);
    checkOutput("blink_still_off", blink, 0);
    idle(1);
    checkOutput("blink_toggled", blink, 1);
    applyStimulus(0, 1, 0);
    checkOutput("blink_forced_off", blink, 0);

    // Reset mid-edit discards the shadow without a load.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_run_en", run_en, 1);
    checkOutput("midrst_sel", sel, 0);
    checkOutput("midrst_load", load, 0);
    checkOutput("midrst_h", load_h, 0);
    checkOutput("midrst_no_load", load_count, load_mark);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
